// File: rtl/vfifo_sc_fifo_ctrl_pkg.sv
// Shared constants and sizing helpers for the single-clock FIFO controller.
// Holds the RAM depth / level-width helpers and the output-buffer depth.
package vfifo_sc_fifo_ctrl_pkg;

  localparam int unsigned OB_DEPTH = 2;
  localparam int unsigned OB_CNT_W = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Level spans 0..DEPTH+OB_DEPTH, so two bits above the address width.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 32'd2;
  endfunction

endpackage

// File: rtl/vfifo_ctrl_obuf.sv
// Two-entry FWFT output buffer fed by the RAM read port; ob0 is the head.
// rd_data holds its last value while empty and across a flush.
module vfifo_ctrl_obuf
  import vfifo_sc_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [OB_CNT_W-1:0]   ob_cnt_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic [OB_CNT_W-1:0]   cnt_q, cnt_d, cnt_after;
  logic                  valid_q, valid_d;

  // Pop shifts first, then the returning RAM word fills the first free slot.
  always_comb begin
    ob0_d     = ob0_q;
    ob1_d     = ob1_q;
    cnt_d     = cnt_q;
    cnt_after = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_after = cnt_q - OB_CNT_W'(pop_i);
      if (pop_i && (cnt_q == OB_CNT_W'(OB_DEPTH))) begin
        ob0_d = ob1_q;
      end
      if (load_i) begin
        if (cnt_after == '0) begin
          ob0_d = data_i;
        end else begin
          ob1_d = data_i;
        end
      end
      cnt_d = cnt_after + OB_CNT_W'(load_i);
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob0_q   <= '0;
      ob1_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ob0_q   <= ob0_d;
      ob1_q   <= ob1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign ob_cnt_o   = cnt_q;
  assign rd_valid_o = valid_q;
  assign rd_data_o  = ob0_q;

endmodule

// File: rtl/vfifo_sc_fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external 1-cycle-read dual-port RAM.
// Define VFIFO_CTRL_FLAGS_EN to enable registered almost_full/almost_empty flags.
module vfifo_sc_fifo_ctrl
  import vfifo_sc_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AFULL_THR  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] ram_adr_a_o,
  output logic [DATA_WIDTH-1:0] ram_d_a_o,
  output logic                  ram_we_a_o,
  output logic [ADDR_WIDTH-1:0] ram_adr_b_o,
  output logic [DATA_WIDTH-1:0] ram_d_b_o,
  output logic                  ram_we_b_o,
  input  logic [DATA_WIDTH-1:0] ram_q_b_i,
  output logic [ADDR_WIDTH+1:0] level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned LVL_W = level_width(ADDR_WIDTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  if ((AFULL_THR == 0) || (AEMPTY_THR >= AFULL_THR)) begin : g_thr_check
    $error("vfifo_sc_fifo_ctrl: AEMPTY_THR must be below a non-zero AFULL_THR");
  end

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  push, pop, rd_iss;
  logic [OB_CNT_W-1:0]   ob_cnt;
  logic                  ob_valid;

  // Issue only when the word will have an ob slot by the time it returns.
  always_comb begin
    push   = wr_valid_i & wr_ready_q;
    pop    = ob_valid & rd_ready_i;
    rd_iss = (ram_cnt_q != '0) &&
             ((3'(ob_cnt) + 3'(inflight_q)) < (3'(OB_DEPTH) + 3'(pop)));

    wptr_d     = wptr_q + ADDR_WIDTH'(push);
    rptr_d     = rptr_q + ADDR_WIDTH'(rd_iss);
    ram_cnt_d  = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_iss);
    inflight_d = rd_iss;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    if (clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      level_d    = '0;
    end
    wr_ready_d = (ram_cnt_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  vfifo_ctrl_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .load_i     (inflight_q),
    .data_i     (ram_q_b_i),
    .pop_i      (pop),
    .ob_cnt_o   (ob_cnt),
    .rd_valid_o (ob_valid),
    .rd_data_o  (rd_data_o)
  );

`ifdef VFIFO_CTRL_FLAGS_EN
  logic afull_q, afull_d, aempty_q, aempty_d;

  // Flags track next-state level so they line up with level_o.
  always_comb begin
    afull_d  = (32'(level_d) >= AFULL_THR);
    aempty_d = (32'(level_d) <= AEMPTY_THR);
    if (clr_i) begin
      afull_d  = 1'b0;
      aempty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
`else
  assign almost_full_o  = 1'b0;
  assign almost_empty_o = 1'b0;
`endif

  assign wr_ready_o  = wr_ready_q;
  assign rd_valid_o  = ob_valid;
  assign level_o     = level_q;
  assign ram_adr_a_o = wptr_q;
  assign ram_d_a_o   = wr_data_i;
  assign ram_we_a_o  = push;
  assign ram_adr_b_o = rptr_q;
  assign ram_d_b_o   = '0;
  assign ram_we_b_o  = 1'b0;

endmodule

// File: tb/tb_vfifo_sc_fifo_ctrl.sv
// Scoreboard bench for vfifo_sc_fifo_ctrl with a behavioural 1-cycle-read RAM (DEPTH=8).
// Pushed words are queued by the driver; a negedge monitor checks every pop.
module tb_vfifo_sc_fifo_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
`ifdef VFIFO_CTRL_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW-1:0] adr_a, adr_b;
  logic [DW-1:0] d_a, d_b, q_b;
  logic          we_a, we_b;
  logic [AW+1:0] level;
  logic          afull, aempty;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            n_acc = 0;
  int            n_pop = 0;

  always #5 clk = ~clk;

  vfifo_sc_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_THR  (6),
    .AEMPTY_THR (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (clr),
    .wr_valid_i     (wr_valid),
    .wr_data_i      (wr_data),
    .wr_ready_o     (wr_ready),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .rd_ready_i     (rd_ready),
    .ram_adr_a_o    (adr_a),
    .ram_d_a_o      (d_a),
    .ram_we_a_o     (we_a),
    .ram_adr_b_o    (adr_b),
    .ram_d_b_o      (d_b),
    .ram_we_b_o     (we_b),
    .ram_q_b_i      (q_b),
    .level_o        (level),
    .almost_full_o  (afull),
    .almost_empty_o (aempty)
  );

  always @(posedge clk) begin
    if (we_a) mem[adr_a] <= d_a;
    q_b <= mem[adr_b];
  end

  // Pop monitor: inputs change just after posedge, so negedge sees what the next edge consumes.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (rst_n && !clr && rd_valid && rd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h expected no word", rd_data);
      end else begin
        exp_d = exp_q.pop_front();
        n_pop++;
        if (rd_data !== exp_d) begin
          bad++;
          $display("FAIL pop_data got=%h exp=%h", rd_data, exp_d);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    if (wr_valid && wr_ready && !clr && rst_n) begin
      exp_q.push_back(wr_data);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int tries, input logic [DW-1:0] base, output int acc);
    acc = 0;
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < tries; i++) begin
      wr_data = base + DW'(acc);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while (level != 0 && k < 40) begin
      tick();
      k++;
    end
    rd_ready = 1'b0;
    chk({nm, "_level"}, longint'(level), 0);
    chk({nm, "_sb_left"}, longint'(exp_q.size()), 0);
    chk({nm, "_rd_valid"}, longint'(rd_valid), 0);
    chk({nm, "_wptr"}, longint'(adr_a), longint'(n_acc % 8));
    chk({nm, "_rptr"}, longint'(adr_b), longint'(n_acc % 8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, gaps, cnt, pops0;
    bit seen;
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_wr_ready", longint'(wr_ready), 1);
    chk("rst_rd_valid", longint'(rd_valid), 0);
    chk("rst_rd_data", longint'(rd_data), 0);
    chk("rst_level", longint'(level), 0);
    chk("rst_afull", longint'(afull), 0);
    chk("rst_aempty", longint'(aempty), longint'(FLAGS));
    chk("ram_we_b", longint'(we_b), 0);
    chk("ram_d_b", longint'(d_b), 0);

    // Latency: push at edge 0, visible after edge 2.
    wr_valid = 1'b1; wr_data = 16'h00A5;
    tick();
    wr_valid = 1'b0;
    chk("lat_level_e0", longint'(level), 1);
    tick();
    chk("lat_valid_e1", longint'(rd_valid), 0);
    tick();
    chk("lat_valid_e2", longint'(rd_valid), 1);
    chk("lat_data_e2", longint'(rd_data), 16'h00A5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("lat_level_pop", longint'(level), 0);
    chk("lat_valid_pop", longint'(rd_valid), 0);
    chk("lat_hold_data", longint'(rd_data), 16'h00A5);

    // Fill: 8 RAM + 2 ob words, extra pushes ignored.
    fill(12, 16'h0100, acc);
    chk("fill_accepted", longint'(acc), 10);
    chk("fill_level", longint'(level), 10);
    chk("fill_wr_ready", longint'(wr_ready), 0);
    chk("fill_head", longint'(rd_data), 16'h0100);
    drain("fill_drain");

    // Streaming: continuous push+pop, no bubbles once primed.
    pops0 = n_pop; gaps = 0; cnt = 0; seen = 1'b0;
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 16'h2000 + DW'(cnt);
      if (wr_ready) cnt++;
      tick();
      if (rd_valid) seen = 1'b1;
      else if (seen) gaps++;
    end
    chk("stream_pushed", longint'(cnt), 100);
    chk("stream_gaps", longint'(gaps), 0);
    drain("stream_drain");
    chk("stream_popped", longint'(n_pop - pops0), 100);

    // Wrap: repeated fill/drain walks the pointers through 7->0.
    for (int r = 0; r < 3; r++) begin
      fill(10, 16'h3000 + DW'(r * 16), acc);
      chk("wrap_accepted", longint'(acc), 10);
      drain("wrap_drain");
    end

    // Flush with a read in flight and level 5.
    fill(6, 16'h4000, acc);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("flush_pre_level", longint'(level), 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    n_acc = 0;
    chk("flush_level", longint'(level), 0);
    chk("flush_rd_valid", longint'(rd_valid), 0);
    chk("flush_wr_ready", longint'(wr_ready), 1);
    chk("flush_wptr", longint'(adr_a), 0);
    tick();
    chk("flush_no_stale", longint'(rd_valid), 0);
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    chk("flush_new_valid", longint'(rd_valid), 1);
    chk("flush_new_data", longint'(rd_data), 16'hBEEF);
    drain("flush_drain");

    // Flags versus level, one push per edge.
    wr_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wr_data = 16'h5000 + DW'(k);
      tick();
      chk("flag_level", longint'(level), longint'(k));
      chk("flag_afull", longint'(afull), longint'(FLAGS && (k >= 6)));
      chk("flag_aempty", longint'(aempty), longint'(FLAGS && (k <= 2)));
    end
    wr_valid = 1'b0;
    drain("flag_drain");

    // Asynchronous reset mid-operation.
    wr_valid = 1'b1; wr_data = 16'h6000;
    tick();
    tick();
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", longint'(level), 0);
    chk("arst_rd_valid", longint'(rd_valid), 0);
    chk("arst_wr_ready", longint'(wr_ready), 1);
    exp_q.delete();
    n_acc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("arst_level_after", longint'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
